// File: rtl/seg_scan_decoder.sv
// Decodes a multiplexed active-low 7-segment scan back into a 16-bit hex value, one pulse per frame.
// Optional SEG_INPUT_SYNC_EN adds a two-flop input synchronizer for asynchronous pin sources.
module seg_scan_decoder #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic        ca,
  input  logic        cb,
  input  logic        cc,
  input  logic        cd,
  input  logic        ce,
  input  logic        cf,
  input  logic        cg,
  output logic [15:0] value,
  output logic [3:0]  blank,
  output logic        frame_valid,
  output logic        changed,
  output logic        err,
  output logic        stale
);

  localparam int              TW          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0]      SETTLE_MAX  = 8'(SETTLE_CYCLES);
  localparam logic [TW-1:0]   TO_MAX      = TW'(TIMEOUT_CYCLES);

  logic [10:0] raw_in;
  logic [10:0] s_in;
  assign raw_in = {an, cg, cf, ce, cd, cc, cb, ca};

`ifdef SEG_INPUT_SYNC_EN
  logic [10:0] sync1_q, sync2_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end
  assign s_in = sync2_q;
`else
  assign s_in = raw_in;
`endif

  logic [10:0] samp_q;
  logic [7:0]  settle_q;
  logic [15:0] scr_val_q, scr_val_d;
  logic [3:0]  scr_blank_q, scr_blank_d;
  logic [3:0]  mask_q, mask_d;
  logic [TW-1:0] to_q;
  logic [15:0] value_q;
  logic [3:0]  blank_q;
  logic        fv_q, changed_q, err_q, stale_q;

  // Sample register starts at the idle pattern so reset never looks like a multi-anode error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      samp_q   <= '1;
      settle_q <= '0;
    end else begin
      samp_q <= s_in;
      if (s_in != samp_q)
        settle_q <= '0;
      else if (settle_q != SETTLE_MAX)
        settle_q <= settle_q + 8'd1;
    end
  end

  logic       settled;
  logic [1:0] sel_k;
  logic       sel_one, sel_multi;
  assign settled = (settle_q == SETTLE_LAST);

  always_comb begin
    sel_k     = 2'd0;
    sel_one   = 1'b1;
    sel_multi = 1'b0;
    case (samp_q[10:7])
      4'b1110: sel_k = 2'd0;
      4'b1101: sel_k = 2'd1;
      4'b1011: sel_k = 2'd2;
      4'b0111: sel_k = 2'd3;
      4'b1111: sel_one = 1'b0;
      default: begin
        sel_one   = 1'b0;
        sel_multi = 1'b1;
      end
    endcase
  end

  logic [3:0] dec_nib;
  logic       dec_blank, dec_bad;
  always_comb begin
    dec_nib   = 4'h0;
    dec_blank = 1'b0;
    dec_bad   = 1'b0;
    case (samp_q[6:0])
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h10: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
      7'h7F: dec_blank = 1'b1;
      default: begin
        dec_blank = 1'b1;
        dec_bad   = 1'b1;
      end
    endcase
  end

  logic cap;
  assign cap = settled & sel_one;

  // Frame completion clears the mask first so a same-cycle capture lands in the new frame.
  always_comb begin
    mask_d      = mask_q;
    scr_val_d   = scr_val_q;
    scr_blank_d = scr_blank_q;
    if (mask_q == 4'hF)
      mask_d = 4'h0;
    if (cap) begin
      mask_d[sel_k]                   = 1'b1;
      scr_val_d[{sel_k, 2'b00} +: 4]  = dec_nib;
      scr_blank_d[sel_k]              = dec_blank;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q      <= '0;
      scr_val_q   <= '0;
      scr_blank_q <= '0;
      value_q     <= '0;
      blank_q     <= 4'hF;
      fv_q        <= 1'b0;
      changed_q   <= 1'b0;
      err_q       <= 1'b0;
      stale_q     <= 1'b0;
      to_q        <= '0;
    end else begin
      mask_q      <= mask_d;
      scr_val_q   <= scr_val_d;
      scr_blank_q <= scr_blank_d;
      if (mask_q == 4'hF) begin
        value_q   <= scr_val_q;
        blank_q   <= scr_blank_q;
        fv_q      <= 1'b1;
        changed_q <= ({scr_val_q, scr_blank_q} != {value_q, blank_q});
      end else begin
        fv_q      <= 1'b0;
        changed_q <= 1'b0;
      end
      if (settled & (sel_multi | (sel_one & dec_bad)))
        err_q <= 1'b1;
      if (cap) begin
        to_q    <= '0;
        stale_q <= 1'b0;
      end else if (to_q != TO_MAX) begin
        to_q    <= to_q + 1'b1;
        stale_q <= ((to_q + 1'b1) == TO_MAX);
      end
    end
  end

  assign value       = value_q;
  assign blank       = blank_q;
  assign frame_valid = fv_q;
  assign changed     = changed_q;
  assign err         = err_q;
  assign stale       = stale_q;

endmodule
